instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Parametrised instruction fetch stage for the simple computer datapath. It holds a loadable instruction store and a program counter, and streams one instruction per cycle to the control unit and register-file/ALU. It replaces the fixed free-running instruction memory. New capabilities: run/halt control, stall, branch redirect, halt-opcode detection and address-error flagging.

Parameters:
INSTR_W, 24, instruction width in bits; opcode is instr[INSTR_W-1 -: OP_W]
OP_W, 4, opcode field width
DEPTH, 16, instruction store entries (2..256, need not be a power of 2)
ADDR_W, 4, PC/address width; must satisfy 2**ADDR_W >= DEPTH
HALT_OP, 4'hF, opcode value that stops fetching

Ports:
clk  in  1  single system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
load_en  in  1  write load_data into store at load_addr (IDLE/HALT only)
load_addr  in  ADDR_W  store write address
load_data  in  INSTR_W  store write data
start  in  1  begin execution from address 0 (IDLE/HALT only)
stall  in  1  freeze PC and outputs for this cycle
branch_en  in  1  redirect fetch to branch_target
branch_target  in  ADDR_W  redirect address
instr  out  INSTR_W  registered fetched instruction
instr_valid  out  1  instr is a new instruction this cycle
pc  out  ADDR_W  address of the next fetch
halted  out  1  high while in HALT
wrap  out  1  one-cycle pulse when PC wraps DEPTH-1 -> 0
addr_err  out  1  sticky; set on out-of-range branch_target or load_addr

Behaviour:
- Reset, async: state=IDLE, pc=0, instr=0, instr_valid=0, halted=0, wrap=0, addr_err=0. Store contents are NOT cleared. Reset mid-RUN aborts immediately; no partial write occurs.
- FSM states: IDLE, RUN, HALT. IDLE -start-> RUN. RUN -halt opcode fetched-> HALT. HALT -start-> RUN. No other transitions except reset.
- Load: in IDLE/HALT, load_en writes mem[load_addr] on the clock edge. Ignored in RUN. load_addr >= DEPTH: write dropped, addr_err set.
- start in IDLE/HALT: pc<=0, state<=RUN, instr_valid<=0, halted<=0. start in RUN is ignored.
- Same-edge load_en and start: the write completes, and the first RUN fetch (next cycle) sees the new data.
- RUN fetch, per cycle, in priority order:
  1. branch_en=1 (overrides stall): pc<=branch_target, instr<=0, instr_valid<=0 (one bubble). If branch_target >= DEPTH: pc<=0 and addr_err set.
  2. stall=1: pc, instr and instr_valid hold their values. A held valid stays high and is the same instruction.
  3. Otherwise: instr<=mem[pc], instr_valid<=1. pc<=pc+1, or 0 if pc==DEPTH-1, in which case wrap pulses for 1 cycle.
- Latency: the instruction at address A appears on instr one cycle after the edge at which pc==A is sampled.
- Halt: if the fetched word's opcode == HALT_OP, it is output with instr_valid=1 on that edge, pc does not advance, and state<=HALT. In HALT: instr_valid=0 from the next cycle, instr holds the halt word, halted=1, and stall/branch_en are ignored.
- IDLE: instr_valid=0, pc holds, stall/branch_en are ignored.
- wrap is 0 except on the wrapping edge. addr_err is cleared only by reset.

Test Plan:
- Load mem[0..2]=24'h1_2_3_4_05, 24'h2_3_1_2_00, 24'hF_0_0_0_00, then start -> instr sequence 0x123405, 0x231200, 0xF00000 with valid=1 on 3 consecutive cycles; then halted=1, pc=2, instr_valid=0.
- RUN with stall high for 3 cycles after the 1st fetch -> instr stays 0x123405 with valid=1 and pc stays 1 for 3 cycles; the sequence then resumes without skipping 0x231200.
- branch_en with target=5 while pc=2, mem[5]=0x300007 -> 1 bubble (valid=0, instr=0), then instr=0x300007 and pc=6. A simultaneous stall does not block the branch.
- DEPTH=16, no halt word, run past address 15 -> wrap=1 for exactly 1 cycle, pc=0, next instr=mem[0]. A DEPTH=10 build wraps 9->0 instead. Branch target=12 with DEPTH=10 -> pc=0 and addr_err=1.
- Assert reset for 1 ns mid-RUN between clock edges -> all outputs zero immediately. Store contents survive, and start re-runs the program from mem[0].
- load_en during RUN -> store unchanged (verified by fetching the same address again after halt+start).

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: loadable instruction store, program counter,
// run/halt control, stall, branch redirect and address-error flagging.
module instr_fetch_unit #(
    parameter int INSTR_W = 24,
    parameter int OP_W = 4,
    parameter int DEPTH = 16,
    parameter int ADDR_W = 4,
    parameter logic [OP_W-1:0] HALT_OP = 4'hF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    input  logic               start,
    input  logic               stall,
    input  logic               branch_en,
    input  logic [ADDR_W-1:0]  branch_target,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted,
    output logic               wrap,
    output logic               addr_err
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    localparam logic [ADDR_W:0]   LIMIT = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DEPTH - 1);

    state_t             state;
    logic [INSTR_W-1:0] mem [DEPTH];
    logic [INSTR_W-1:0] word;
    logic               load_ok;
    logic               load_bad;
    logic               tgt_bad;
    logic               is_halt;

    assign load_ok  = load_en && (state != RUN);
    assign load_bad = {1'b0, load_addr} >= LIMIT;
    assign tgt_bad  = {1'b0, branch_target} >= LIMIT;
    assign word     = mem[pc];
    assign is_halt  = word[INSTR_W-1 -: OP_W] == HALT_OP;

    // The store has no reset so a program survives a reset pulse.
    always_ff @(posedge clk) begin
        if (!reset && load_ok && !load_bad)
            mem[load_addr] <= load_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            wrap        <= 1'b0;
            addr_err    <= 1'b0;
        end else begin
            wrap <= 1'b0;
            if (load_ok && load_bad)
                addr_err <= 1'b1;
            unique case (state)
                IDLE, HALT: begin
                    instr_valid <= 1'b0;
                    if (start) begin
                        pc     <= '0;
                        state  <= RUN;
                        halted <= 1'b0;
                    end
                end
                RUN: begin
                    if (branch_en) begin
                        instr       <= '0;
                        instr_valid <= 1'b0;
                        if (tgt_bad) begin
                            pc       <= '0;
                            addr_err <= 1'b1;
                        end else begin
                            pc <= branch_target;
                        end
                    end else if (!stall) begin
                        instr       <= word;
                        instr_valid <= 1'b1;
                        // A halt word is delivered but pc stays on it.
                        if (is_halt) begin
                            state  <= HALT;
                            halted <= 1'b1;
                        end else if (pc == LAST) begin
                            pc   <= '0;
                            wrap <= 1'b1;
                        end else begin
                            pc <= pc + ADDR_W'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: DEPTH=16 stream checks plus
// a DEPTH=10 instance for wrap and out-of-range branch handling.
module tb_instr_fetch_unit;

    localparam int IW = 24;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          load_en, start, stall, branch_en;
    logic [AW-1:0] load_addr, branch_target;
    logic [IW-1:0] load_data;
    logic [IW-1:0] instr;
    logic          instr_valid, halted, wrap, addr_err;
    logic [AW-1:0] pc;

    logic          load_en10, start10, stall10, branch_en10;
    logic [AW-1:0] load_addr10, branch_target10;
    logic [IW-1:0] load_data10;
    logic [IW-1:0] instr10;
    logic          instr_valid10, halted10, wrap10, addr_err10;
    logic [AW-1:0] pc10;

    instr_fetch_unit #(.DEPTH(16), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .start(start), .stall(stall),
        .branch_en(branch_en), .branch_target(branch_target),
        .instr(instr), .instr_valid(instr_valid), .pc(pc),
        .halted(halted), .wrap(wrap), .addr_err(addr_err)
    );

    instr_fetch_unit #(.DEPTH(10), .ADDR_W(AW)) dut10 (
        .clk(clk), .reset(reset),
        .load_en(load_en10), .load_addr(load_addr10), .load_data(load_data10),
        .start(start10), .stall(stall10),
        .branch_en(branch_en10), .branch_target(branch_target10),
        .instr(instr10), .instr_valid(instr_valid10), .pc(pc10),
        .halted(halted10), .wrap(wrap10), .addr_err(addr_err10)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
        logic          wrap;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   total = 0;
    int   bad = 0;
    int   wrap_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [IW-1:0] i, input logic [AW-1:0] p,
                        input logic w);
        exp_t x;
        x.instr = i;
        x.pc    = p;
        x.wrap  = w;
        q.push_back(x);
    endtask

    // Monitor: every valid output cycle consumes one expected entry.
    always @(negedge clk) begin
        if (wrap) wrap_cnt++;
        if (!reset && instr_valid) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got instr %h want none", instr);
            end else begin
                e = q.pop_front();
                chk("sb_instr", 32'(instr), 32'(e.instr));
                chk("sb_pc", 32'(pc), 32'(e.pc));
                chk("sb_wrap", 32'(wrap), 32'(e.wrap));
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [IW-1:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic load10(input logic [AW-1:0] a, input logic [IW-1:0] d);
        load_en10   = 1'b1;
        load_addr10 = a;
        load_data10 = d;
        tick();
        load_en10 = 1'b0;
    endtask

    task automatic go;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic drain(input string name);
        int k = 0;
        while (q.size() != 0 && k < 40) begin
            tick();
            k++;
        end
        chk(name, 32'(q.size()), 32'd0);
        q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_instr"}, 32'(instr), 32'd0);
        chk({tag, "_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, "_pc"}, 32'(pc), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_wrap"}, 32'(wrap), 32'd0);
        chk({tag, "_err"}, 32'(addr_err), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        load_en = 0; start = 0; stall = 0; branch_en = 0;
        load_addr = 0; branch_target = 0; load_data = 0;
        load_en10 = 0; start10 = 0; stall10 = 0; branch_en10 = 0;
        load_addr10 = 0; branch_target10 = 0; load_data10 = 0;
        #12;
        chk_zero("rst");
        reset = 1'b0;
        tick();

        // Basic program ending in a halt word
        load(0, 24'h123405);
        load(1, 24'h231200);
        load(2, 24'hF00000);
        push(24'h123405, 1, 0);
        push(24'h231200, 2, 0);
        push(24'hF00000, 2, 0);
        go();
        drain("s1_drain");
        chk("s1_halted", 32'(halted), 32'd1);
        chk("s1_pc", 32'(pc), 32'd2);
        chk("s1_valid", 32'(instr_valid), 32'd0);
        chk("s1_instr", 32'(instr), 32'hF00000);

        // Three stall cycles after the first fetch
        repeat (4) push(24'h123405, 1, 0);
        push(24'h231200, 2, 0);
        push(24'hF00000, 2, 0);
        go();
        tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        drain("s2_drain");

        // Branch with simultaneous stall while pc=2
        load(5, 24'h300007);
        load(6, 24'hF00006);
        push(24'h123405, 1, 0);
        push(24'h231200, 2, 0);
        push(24'h300007, 6, 0);
        push(24'hF00006, 6, 0);
        go();
        tick();
        tick();
        branch_en = 1'b1;
        branch_target = 5;
        stall = 1'b1;
        tick();
        branch_en = 1'b0;
        stall = 1'b0;
        chk("br_valid", 32'(instr_valid), 32'd0);
        chk("br_instr", 32'(instr), 32'd0);
        chk("br_pc", 32'(pc), 32'd5);
        drain("s3_drain");

        // Full run without halt: wrap 15->0, then async reset mid-RUN
        for (int i = 0; i < 16; i++) load(AW'(i), 24'h100000 | IW'(i));
        for (int i = 0; i < 16; i++)
            push(24'h100000 | IW'(i), (i == 15) ? AW'(0) : AW'(i + 1), i == 15);
        push(24'h100000, 1, 0);
        wrap_cnt = 0;
        go();
        repeat (17) tick();
        #6;
        reset = 1'b1;
        #1;
        chk_zero("midrst");
        chk("wrap_cnt", 32'(wrap_cnt), 32'd1);
        chk("s4_queue", 32'(q.size()), 32'd0);
        q.delete();
        reset = 1'b0;
        tick();

        // Store survives reset; loads during RUN are dropped
        load(2, 24'hF00002);
        push(24'h100000, 1, 0);
        push(24'h100001, 2, 0);
        push(24'hF00002, 2, 0);
        go();
        load_en = 1'b1;
        load_addr = 0;
        load_data = 24'hABCDEF;
        tick();
        tick();
        load_en = 1'b0;
        drain("s5_drain");
        chk("s5_halted", 32'(halted), 32'd1);
        push(24'h100000, 1, 0);
        push(24'h100001, 2, 0);
        push(24'hF00002, 2, 0);
        go();
        drain("s5_rerun");

        // Same-edge load and start: first fetch sees the new word
        push(24'h200000, 1, 0);
        push(24'h100001, 2, 0);
        push(24'hF00002, 2, 0);
        load_en = 1'b1;
        load_addr = 0;
        load_data = 24'h200000;
        start = 1'b1;
        tick();
        load_en = 1'b0;
        start = 1'b0;
        drain("s6_drain");
        chk("s6_err", 32'(addr_err), 32'd0);

        // DEPTH=10 build: bad load address, wrap 9->0, bad branch
        for (int i = 0; i < 10; i++) load10(AW'(i), 24'h500000 | IW'(i));
        chk("d10_err0", 32'(addr_err10), 32'd0);
        load10(12, 24'h777777);
        chk("d10_load_err", 32'(addr_err10), 32'd1);
        reset = 1'b1;
        #1;
        chk("d10_err_clr", 32'(addr_err10), 32'd0);
        reset = 1'b0;
        tick();
        start10 = 1'b1;
        tick();
        start10 = 1'b0;
        repeat (10) tick();
        chk("d10_wrap_instr", 32'(instr10), 32'h500009);
        chk("d10_wrap_pc", 32'(pc10), 32'd0);
        chk("d10_wrap", 32'(wrap10), 32'd1);
        chk("d10_wrap_valid", 32'(instr_valid10), 32'd1);
        tick();
        chk("d10_next_instr", 32'(instr10), 32'h500000);
        chk("d10_next_pc", 32'(pc10), 32'd1);
        chk("d10_wrap_off", 32'(wrap10), 32'd0);
        branch_en10 = 1'b1;
        branch_target10 = 12;
        tick();
        branch_en10 = 1'b0;
        chk("d10_br_pc", 32'(pc10), 32'd0);
        chk("d10_br_err", 32'(addr_err10), 32'd1);
        chk("d10_br_valid", 32'(instr_valid10), 32'd0);
        chk("d10_br_instr", 32'(instr10), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
